// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
//   Shared types and constants for the instruction sequencer:
//     - state_t      : sequencer FSM states
//     - OP_*         : 4-bit opcode values carried in ir[15:12]
//     - U_*          : execution-unit indices (bit position in unit_start)
//     - decode_t     : result of opcode decode {valid, is_nop, unit}
//     - decode_opcode: opcode -> decode_t mapping
// ---------------------------------------------------------------------------
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ISSUE  = 3'd3,
        S_WAIT   = 3'd4,
        S_RETIRE = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_SUBI = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_LD   = 4'h5;
    localparam logic [3:0] OP_ST   = 4'h6;
    localparam logic [3:0] OP_BR   = 4'h7;

    // Unit index is kept wider than strictly needed so that a build with
    // fewer units can still detect opcodes that map beyond NUM_UNITS.
    localparam int UNIT_W = 3;
    typedef logic [UNIT_W-1:0] unit_idx_t;

    localparam unit_idx_t U_ALUI = 3'd0;
    localparam unit_idx_t U_ALUR = 3'd1;
    localparam unit_idx_t U_LS   = 3'd2;
    localparam unit_idx_t U_BR   = 3'd3;

    typedef struct packed {
        logic      valid;   // opcode is defined
        logic      is_nop;  // no unit is started, go straight to retire
        unit_idx_t unit;    // target unit when valid and not a NOP
    } decode_t;

    function automatic decode_t decode_opcode(input logic [3:0] op);
        decode_t d;
        d = '0;
        case (op)
            OP_NOP:          begin d.valid = 1'b1; d.is_nop = 1'b1; end
            OP_ADDI, OP_SUBI: begin d.valid = 1'b1; d.unit = U_ALUI; end
            OP_ADD,  OP_SUB:  begin d.valid = 1'b1; d.unit = U_ALUR; end
            OP_LD,   OP_ST:   begin d.valid = 1'b1; d.unit = U_LS;   end
            OP_BR:           begin d.valid = 1'b1; d.unit = U_BR;   end
            default:         d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/bus_conflict_mon.sv
// ---------------------------------------------------------------------------
// bus_conflict_mon
//   Watches the shared-bus drive enables every cycle and raises a sticky
//   flag the first time more than one enable is high. Runs regardless of
//   the sequencer state; only rst clears the flag.
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset
//   bus_oe   in   [W-1:0] drive enables
//   conflict out  sticky multi-driver flag (registered)
// ---------------------------------------------------------------------------
module bus_conflict_mon #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] bus_oe,
    output logic         conflict
);

    logic         conflict_reg;
    logic         multi_drive;
    logic [W-1:0] lowest_cleared;

    // Clearing the lowest set bit leaves something behind only when at
    // least two bits were set, i.e. popcount > 1.
    assign lowest_cleared = bus_oe & (bus_oe - W'(1));
    assign multi_drive    = |lowest_cleared;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_reg <= 1'b0;
        end else if (multi_drive) begin
            conflict_reg <= 1'b1;
        end
    end

    assign conflict = conflict_reg;

endmodule

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//   Fetches a 16-bit instruction, latches it in ir, decodes ir[15:12],
//   pulses start to one execution unit, waits for its done (bounded by
//   TIMEOUT cycles) and then advances or loads the pc. Illegal opcodes and
//   timeouts park the sequencer in a terminal FAULT state. A bus monitor
//   flags any cycle with more than one bus drive enable active.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   run           keep executing while high; sampled in IDLE and RETIRE
//   mem_data/valid instruction word handshake from program memory
//   fetch_req     high in FETCH
//   pc            program counter (registered)
//   ir            latched instruction (registered)
//   unit_start    one-hot one-cycle start pulse (registered)
//   unit_done     done pulses from the execution units
//   pc_load/pc_target  branch redirect, sampled in RETIRE only
//   bus_oe        all shared-bus drive enables
//   bus_conflict  sticky multi-driver flag
//   fault         sticky illegal-opcode / timeout flag
//   busy          high in every state except IDLE and FAULT
// ---------------------------------------------------------------------------
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W      = 8,
    parameter int NUM_UNITS = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [15:0]          mem_data,
    input  logic                 mem_valid,
    output logic                 fetch_req,
    output logic [PC_W-1:0]      pc,
    output logic [15:0]          ir,
    output logic [NUM_UNITS-1:0] unit_start,
    input  logic [NUM_UNITS-1:0] unit_done,
    input  logic                 pc_load,
    input  logic [PC_W-1:0]      pc_target,
    input  logic [7:0]           bus_oe,
    output logic                 bus_conflict,
    output logic                 fault,
    output logic                 busy
);

    localparam int SEL_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);

    state_t                 state_reg;
    logic [PC_W-1:0]        pc_reg;
    logic [15:0]            ir_reg;
    logic [NUM_UNITS-1:0]   unit_start_reg;
    logic                   fault_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [SEL_W-1:0]       sel_reg;

    decode_t                dec;
    logic                   unit_in_range;
    logic [NUM_UNITS-1:0]   start_onehot;

    // Decode straight off the instruction register; ir is stable from
    // DECODE onward so this is valid whenever it is consulted.
    assign dec           = decode_opcode(ir_reg[15:12]);
    assign unit_in_range = (int'(dec.unit) < NUM_UNITS);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_UNITS; gi++) begin : g_onehot
            assign start_onehot[gi] = (dec.unit == UNIT_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            pc_reg         <= '0;
            ir_reg         <= '0;
            unit_start_reg <= '0;
            fault_reg      <= 1'b0;
            cnt_reg        <= '0;
            sel_reg        <= '0;
        end else begin
            // Start is only ever raised on the DECODE->ISSUE edge, so this
            // default keeps it a single-cycle pulse.
            unit_start_reg <= '0;
            case (state_reg)
                S_IDLE: begin
                    if (run) begin
                        state_reg <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (mem_valid) begin
                        ir_reg    <= mem_data;
                        state_reg <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (dec.is_nop) begin
                        state_reg <= S_RETIRE;
                    end else if (!dec.valid || !unit_in_range) begin
                        fault_reg <= 1'b1;
                        state_reg <= S_FAULT;
                    end else begin
                        sel_reg        <= dec.unit[SEL_W-1:0];
                        unit_start_reg <= start_onehot;
                        state_reg      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_reg   <= '0;
                    state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    // Done is tested first so it beats a same-cycle timeout;
                    // done from any other unit is simply not looked at.
                    if (unit_done[sel_reg]) begin
                        state_reg <= S_RETIRE;
                    end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        fault_reg <= 1'b1;
                        state_reg <= S_FAULT;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                S_RETIRE: begin
                    if (pc_load) begin
                        pc_reg <= pc_target;
                    end else begin
                        pc_reg <= pc_reg + PC_W'(1);
                    end
                    state_reg <= run ? S_FETCH : S_IDLE;
                end
                S_FAULT: begin
                    state_reg <= S_FAULT;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    bus_conflict_mon #(
        .W (8)
    ) u_bus_conflict_mon (
        .clk      (clk),
        .rst      (rst),
        .bus_oe   (bus_oe),
        .conflict (bus_conflict)
    );

    assign fetch_req  = (state_reg == S_FETCH);
    assign busy       = (state_reg != S_IDLE) && (state_reg != S_FAULT);
    assign pc         = pc_reg;
    assign ir         = ir_reg;
    assign unit_start = unit_start_reg;
    assign fault      = fault_reg;

endmodule
